// File: rtl/types.sv
// rtl/types.sv - shared core types: FU count, FU index, exe bundle, opid age compare
package types;

    localparam int FU_NUM = 5;

    typedef logic [2:0] fu_idx_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [31:0] result;
        logic        exc;
    } exe_bundle_t;

    // a is older than b when b is less than half the 15-bit opid ring ahead of a
    function automatic logic opid_older(input logic [14:0] a, input logic [14:0] b);
        logic [14:0] d;
        d = b - a;
        return !d[14];
    endfunction

endpackage

// File: rtl/exe_arbiter_rr_picker.sv
// rtl/exe_arbiter_rr_picker.sv - round-robin priority encoder: one-hot grant and index from request and pointer
module rr_picker #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        int   j;
        logic found;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && i_req[j]) begin
                found    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/exe_arbiter.sv
// rtl/exe_arbiter.sv - write-back arbiter from function units into a one-entry ROB stage
// EXE_ARB_AGE_EN selects oldest-opid arbitration instead of round-robin.
module exe_arbiter
    import types::*;
#(
    parameter int NFU = FU_NUM,
    parameter int IDW = $clog2(NFU)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NFU-1:0]    in_valid,
    output logic [NFU-1:0]    in_ready,
    input  exe_bundle_t       in_bundle [NFU],
    output logic              out_valid,
    input  logic              out_ready,
    output exe_bundle_t       out_bundle,
    output logic [IDW-1:0]    out_src,
    input  logic              flush
);

    logic            r_out_valid;
    exe_bundle_t     r_out_bundle;
    logic [IDW-1:0]  r_out_src;
    logic [IDW-1:0]  r_ptr;

    logic            w_can_load;
    logic            w_grant_en;
    logic            w_xfer;
    logic [NFU-1:0]  w_gnt_oh;
    logic [IDW-1:0]  w_gnt_idx;

`ifdef EXE_ARB_AGE_EN
    // Linear scan keeps the lowest index unless a later requester is strictly older.
    always_comb begin
        logic found;
        found     = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        for (int i = 0; i < NFU; i++) begin
            if (in_valid[i] &&
                (!found ||
                 (opid_older(in_bundle[i].opid[14:0], in_bundle[w_gnt_idx].opid[14:0]) &&
                  !opid_older(in_bundle[w_gnt_idx].opid[14:0], in_bundle[i].opid[14:0])))) begin
                found     = 1'b1;
                w_gnt_idx = IDW'(i);
            end
        end
        if (found) w_gnt_oh[w_gnt_idx] = 1'b1;
    end
`else
    rr_picker #(
        .N  (NFU),
        .IW (IDW)
    ) u_rr_picker (
        .i_req (in_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt_oh),
        .o_idx (w_gnt_idx)
    );
`endif

    assign w_can_load = !r_out_valid || out_ready;
    assign w_grant_en = rstn && w_can_load && !flush;
    assign in_ready   = w_grant_en ? w_gnt_oh : '0;
    assign w_xfer     = |in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid  <= 1'b0;
            r_out_bundle <= '0;
            r_out_src    <= '0;
            r_ptr        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_can_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_bundle <= in_bundle[w_gnt_idx];
                r_out_src    <= w_gnt_idx;
`ifndef EXE_ARB_AGE_EN
                r_ptr        <= (int'(w_gnt_idx) == NFU - 1) ? '0 : w_gnt_idx + 1'b1;
`endif
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_bundle = r_out_bundle;
    assign out_src    = r_out_src;

endmodule

// File: tb/tb_exe_arbiter.sv
// tb/tb_exe_arbiter.sv - directed self-checking bench for exe_arbiter
module tb_exe_arbiter;
    import types::*;

    localparam int NFU = 5;
    localparam int IDW = 3;

    logic              clk;
    logic              rstn;
    logic [NFU-1:0]    in_valid;
    logic [NFU-1:0]    in_ready;
    exe_bundle_t       bund [NFU];
    logic              out_valid;
    logic              out_ready;
    exe_bundle_t       out_bundle;
    logic [IDW-1:0]    out_src;
    logic              flush;

    int n_checks;
    int n_fail;

    exe_arbiter #(.NFU(NFU), .IDW(IDW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bundle  (bund),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bundle (out_bundle),
        .out_src    (out_src),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; in_valid = '0; out_ready = 1'b0; flush = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = '1; out_ready = 1'b1; flush = 1'b0;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_src !== 3'd0) begin n_fail++; $display("FAIL reset_out_src got %0d want 0", out_src); end
        n_checks++; if (out_bundle !== exe_bundle_t'('0)) begin n_fail++; $display("FAIL reset_out_bundle got %h want 0", out_bundle); end
        n_checks++; if (in_ready !== 5'b00000) begin n_fail++; $display("FAIL reset_in_ready got %b want 00000", in_ready); end
        n_checks++; if (dut.r_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_ptr got %0d want 0", dut.r_ptr); end
        in_valid = '0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 5'b00001; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 5'b00001) begin n_fail++; $display("FAIL single_in_ready got %b want 00001", in_ready); end
        step();
        in_valid = '0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        n_checks++; if (out_src !== 3'd0) begin n_fail++; $display("FAIL single_out_src got %0d want 0", out_src); end
        n_checks++; if (out_bundle !== bund[0]) begin n_fail++; $display("FAIL single_out_bundle got %h want %h", out_bundle, bund[0]); end
        n_checks++; if (dut.r_ptr !== 3'd1) begin n_fail++; $display("FAIL single_ptr got %0d want 1", dut.r_ptr); end
        step();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_rr_wrap();
        logic [NFU-1:0] exp_oh;
        do_reset();
        in_valid = 5'b11111; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp_oh = 5'b00001 << (k % 5);
            n_checks++; if (in_ready !== exp_oh) begin n_fail++; $display("FAIL rr_in_ready[%0d] got %b want %b", k, in_ready, exp_oh); end
            if (k > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_src !== 3'((k - 1) % 5)) begin
                    n_fail++; $display("FAIL rr_out_src[%0d] got v=%b src=%0d want v=1 src=%0d", k, out_valid, out_src, (k - 1) % 5);
                end
            end
            step();
        end
        in_valid = '0;
        @(negedge clk);
        n_checks++; if (out_src !== 3'd1 || out_bundle !== bund[1]) begin n_fail++; $display("FAIL rr_last got src=%0d bundle=%h want src=1 bundle=%h", out_src, out_bundle, bund[1]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 5'b01000; out_ready = 1'b1;
        step();
        in_valid = 5'b10010; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 5'b00000) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 00000", k, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out_src !== 3'd3 || out_bundle !== bund[3]) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b src=%0d bundle=%h want v=1 src=3 bundle=%h", k, out_valid, out_src, out_bundle, bund[3]);
            end
            step();
        end
        n_checks++; if (dut.r_ptr !== 3'd4) begin n_fail++; $display("FAIL bp_ptr got %0d want 4", dut.r_ptr); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 5'b10000) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 10000", in_ready); end
        step();
        in_valid = '0;
        @(negedge clk);
        n_checks++; if (out_src !== 3'd4 || out_bundle !== bund[4]) begin n_fail++; $display("FAIL bp_release_out got src=%0d bundle=%h want src=4 bundle=%h", out_src, out_bundle, bund[4]); end
        n_checks++; if (dut.r_ptr !== 3'd0) begin n_fail++; $display("FAIL bp_ptr_wrap got %0d want 0", dut.r_ptr); end
    endtask

    task automatic test_flush();
        in_valid = 5'b00100; out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 5'b00000) begin n_fail++; $display("FAIL flush_in_ready got %b want 00000", in_ready); end
        step();
        flush = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        n_checks++; if (dut.r_ptr !== 3'd0) begin n_fail++; $display("FAIL flush_ptr got %0d want 0", dut.r_ptr); end
        n_checks++; if (in_ready !== 5'b00100) begin n_fail++; $display("FAIL flush_regrant got %b want 00100", in_ready); end
        step();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_src !== 3'd2 || out_bundle !== bund[2]) begin
            n_fail++; $display("FAIL flush_after got v=%b src=%0d bundle=%h want v=1 src=2 bundle=%h", out_valid, out_src, out_bundle, bund[2]);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 5'b00001; out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || dut.r_ptr !== 3'd3) begin n_fail++; $display("FAIL mid_pre got v=%b ptr=%0d want v=1 ptr=3", out_valid, dut.r_ptr); end
        rstn = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        n_checks++; if (dut.r_ptr !== 3'd0) begin n_fail++; $display("FAIL mid_ptr got %0d want 0", dut.r_ptr); end
        n_checks++; if (in_ready !== 5'b00000) begin n_fail++; $display("FAIL mid_in_ready got %b want 00000", in_ready); end
        step();
        rstn = 1'b1; in_valid = 5'b00100; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 5'b00100) begin n_fail++; $display("FAIL mid_resume_in_ready got %b want 00100", in_ready); end
        step();
        in_valid = '0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_src !== 3'd2) begin n_fail++; $display("FAIL mid_resume_out got v=%b src=%0d want v=1 src=2", out_valid, out_src); end
    endtask

    task automatic test_age();
        do_reset();
        bund[0].opid = 16'h7FFE; bund[4].opid = 16'h0001;
        in_valid = 5'b10001; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 5'b00001) begin n_fail++; $display("FAIL age_wrap got %b want 00001", in_ready); end
        step();
        bund[1].opid = 16'h0123; bund[2].opid = 16'h0123;
        in_valid = 5'b00110;
        @(negedge clk);
        n_checks++; if (in_ready !== 5'b00010) begin n_fail++; $display("FAIL age_tie got %b want 00010", in_ready); end
        n_checks++; if (out_src !== 3'd0 || dut.r_ptr !== 3'd0) begin n_fail++; $display("FAIL age_out got src=%0d ptr=%0d want src=0 ptr=0", out_src, dut.r_ptr); end
        step();
        in_valid = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < NFU; i++) begin
            bund[i].opid   = {1'(i % 2), 15'(i * 37 + 5)};
            bund[i].result = 32'hC0DE_0000 + 32'(i);
            bund[i].exc    = (i == 3);
        end
        test_reset();
`ifdef EXE_ARB_AGE_EN
        test_age();
`else
        test_single();
        test_rr_wrap();
        test_backpressure();
        test_flush();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
